// File: rtl/parking_pkg.sv
// Shared types for the parking slot allocator.
// Default geometry, FSM states and served-side tag.
package parking_pkg;

  localparam int DEF_SLOTS  = 8;
  localparam int DEF_SLOT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_ENTRY,
    SERVE_EXIT,
    HOLD_ENTRY,
    HOLD_EXIT
  } state_t;

  typedef enum logic {
    ENTRY,
    EXIT
  } side_t;

endpackage

// File: rtl/free_slot_encoder.sv
// Combinational search for the first free slot in allocation order.
// in: occupancy; out: free_slot index, any_free flag.
module free_slot_encoder
  import parking_pkg::*;
#(
  parameter int SLOTS  = DEF_SLOTS,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic [SLOTS-1:0]  occupancy,
  output logic [SLOT_W-1:0] free_slot,
  output logic              any_free
);

  // Upper half ascending, then lower half descending.
  function automatic int order_idx(input int k);
    return (k < SLOTS/2) ? (SLOTS/2 + k) : (SLOTS - 1 - k);
  endfunction

  always_comb begin
    logic [SLOT_W-1:0] idx;
    idx       = '0;
    free_slot = '0;
    any_free  = 1'b0;
    // Walk backwards so the earliest free entry wins.
    for (int k = SLOTS - 1; k >= 0; k--) begin
      idx = SLOT_W'(order_idx(k));
      if (!occupancy[idx]) begin
        free_slot = idx;
        any_free  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_slot_controller.sv
// Entry/exit slot allocator with registered occupancy and counts.
// Ports: entry/exit req-ack handshakes, occupancy, free_count, full, empty.
module parking_slot_controller
  import parking_pkg::*;
#(
  parameter int SLOTS  = DEF_SLOTS,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              entry_req,
  output logic              entry_ack,
  output logic              entry_ok,
  output logic [SLOT_W-1:0] entry_slot,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic              exit_ack,
  output logic              exit_err,
  output logic [SLOTS-1:0]  occupancy,
  output logic [SLOT_W:0]   free_count,
  output logic              full,
  output logic              empty
);

  state_t            state_q, state_d;
  side_t             last_q, last_d;
  logic [SLOTS-1:0]  occ_q, occ_d;
  logic [SLOT_W:0]   free_q, free_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              eack_q, eack_d;
  logic              eok_q, eok_d;
  logic [SLOT_W-1:0] eslot_q, eslot_d;
  logic              xack_q, xack_d;
  logic              xerr_q, xerr_d;

  logic [SLOT_W-1:0] pick;
  logic              any_free;
  logic              go_entry;
  logic              go_exit;

  free_slot_encoder #(
    .SLOTS  (SLOTS),
    .SLOT_W (SLOT_W)
  ) u_enc (
    .occupancy (occ_q),
    .free_slot (pick),
    .any_free  (any_free)
  );

  function automatic logic [SLOT_W:0] ones(
    input logic [SLOTS-1:0] v
  );
    logic [SLOT_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < SLOTS; i++)
      cnt = cnt + {{SLOT_W{1'b0}}, v[i]};
    return cnt;
  endfunction

  // On a tie the side not served last wins.
  assign go_entry = entry_req &&
                    (!exit_req || last_q == EXIT);
  assign go_exit  = exit_req &&
                    (!entry_req || last_q == ENTRY);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    occ_d   = occ_q;
    eack_d  = eack_q;
    eok_d   = eok_q;
    eslot_d = eslot_q;
    xack_d  = xack_q;
    xerr_d  = xerr_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          go_entry: state_d = SERVE_ENTRY;
          go_exit:  state_d = SERVE_EXIT;
          default:  state_d = IDLE;
        endcase
      end
      SERVE_ENTRY: begin
        if (any_free) begin
          occ_d[pick] = 1'b1;
          eok_d       = 1'b1;
          eslot_d     = pick;
        end else begin
          eok_d       = 1'b0;
          eslot_d     = '0;
        end
        eack_d  = 1'b1;
        last_d  = ENTRY;
        state_d = HOLD_ENTRY;
      end
      SERVE_EXIT: begin
        if (occ_q[exit_slot]) begin
          occ_d[exit_slot] = 1'b0;
          xerr_d           = 1'b0;
        end else begin
          xerr_d           = 1'b1;
        end
        xack_d  = 1'b1;
        last_d  = EXIT;
        state_d = HOLD_EXIT;
      end
      HOLD_ENTRY: begin
        if (!entry_req) begin
          eack_d  = 1'b0;
          eok_d   = 1'b0;
          eslot_d = '0;
          state_d = IDLE;
        end
      end
      HOLD_EXIT: begin
        if (!exit_req) begin
          xack_d  = 1'b0;
          xerr_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts and flags track the occupancy being written.
  always_comb begin
    free_d  = (SLOT_W+1)'(SLOTS) - ones(occ_d);
    full_d  = (free_d == '0);
    empty_d = (free_d == (SLOT_W+1)'(SLOTS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= ENTRY;
      occ_q   <= '0;
      free_q  <= (SLOT_W+1)'(SLOTS);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      eack_q  <= 1'b0;
      eok_q   <= 1'b0;
      eslot_q <= '0;
      xack_q  <= 1'b0;
      xerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      occ_q   <= occ_d;
      free_q  <= free_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      eack_q  <= eack_d;
      eok_q   <= eok_d;
      eslot_q <= eslot_d;
      xack_q  <= xack_d;
      xerr_q  <= xerr_d;
    end
  end

  assign entry_ack  = eack_q;
  assign entry_ok   = eok_q;
  assign entry_slot = eslot_q;
  assign exit_ack   = xack_q;
  assign exit_err   = xerr_q;
  assign occupancy  = occ_q;
  assign free_count = free_q;
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_parking_slot_controller.sv
// Bench for parking_slot_controller: transaction model plus
// directed vectors with literal expectations.
module tb_parking_slot_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req;
  logic       entry_ack;
  logic       entry_ok;
  logic [2:0] entry_slot;
  logic       exit_req;
  logic [2:0] exit_slot;
  logic       exit_ack;
  logic       exit_err;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic       full;
  logic       empty;

  int total = 0;
  int bad   = 0;

  parking_slot_controller dut (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (entry_req),
    .entry_ack  (entry_ack),
    .entry_ok   (entry_ok),
    .entry_slot (entry_slot),
    .exit_req   (exit_req),
    .exit_slot  (exit_slot),
    .exit_ack   (exit_ack),
    .exit_err   (exit_err),
    .occupancy  (occupancy),
    .free_count (free_count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 serving, 2 holding.
  int         ord [8] = '{4, 5, 6, 7, 3, 2, 1, 0};
  logic [7:0] m_occ;
  int         m_phase;
  int         m_side;
  int         m_last;
  logic       m_eack, m_xack, m_ok, m_err;
  int         m_slot;

  always @(posedge clk or posedge reset) begin
    int  s;
    bit  found;
    if (reset) begin
      m_occ   <= '0;
      m_phase <= 0;
      m_side  <= 0;
      m_last  <= 0;
      m_eack  <= 1'b0;
      m_xack  <= 1'b0;
      m_ok    <= 1'b0;
      m_err   <= 1'b0;
      m_slot  <= 0;
    end else if (m_phase == 0) begin
      if (entry_req && exit_req) begin
        m_side  <= (m_last == 0) ? 1 : 0;
        m_phase <= 1;
      end else if (entry_req) begin
        m_side  <= 0;
        m_phase <= 1;
      end else if (exit_req) begin
        m_side  <= 1;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (m_side == 0) begin
        s = 0;
        found = 0;
        foreach (ord[k])
          if (!found && !m_occ[ord[k]]) begin
            s = ord[k];
            found = 1;
          end
        if (found) m_occ[s] <= 1'b1;
        m_ok   <= found;
        m_slot <= found ? s : 0;
        m_eack <= 1'b1;
      end else begin
        if (m_occ[exit_slot]) m_occ[exit_slot] <= 1'b0;
        m_err  <= !m_occ[exit_slot];
        m_xack <= 1'b1;
      end
      m_last  <= m_side;
      m_phase <= 2;
    end else begin
      if (m_side == 0 && !entry_req) begin
        m_eack  <= 1'b0;
        m_phase <= 0;
      end
      if (m_side == 1 && !exit_req) begin
        m_xack  <= 1'b0;
        m_phase <= 0;
      end
    end
  end

  always @(negedge clk) begin
    int f;
    f = 8 - $countones(m_occ);
    chk("occupancy", int'(occupancy), int'(m_occ));
    chk("free_count", int'(free_count), f);
    chk("full", int'(full), int'(f == 0));
    chk("empty", int'(empty), int'(f == 8));
    chk("entry_ack", int'(entry_ack), int'(m_eack));
    chk("exit_ack", int'(exit_ack), int'(m_xack));
    if (m_eack) begin
      chk("entry_ok", int'(entry_ok), int'(m_ok));
      if (m_ok) chk("entry_slot", int'(entry_slot), m_slot);
    end
    if (m_xack) chk("exit_err", int'(exit_err), int'(m_err));
  end

  task automatic wait_ack(input bit ex, input bit lvl);
    bit got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((ex ? exit_ack : entry_ack) == lvl) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: side=%0d got %0d expected %0d",
               ex, !lvl, lvl);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic entry_txn(output bit ok, output int slot);
    step();
    entry_req = 1'b1;
    wait_ack(0, 1);
    ok   = entry_ok;
    slot = int'(entry_slot);
    step();
    entry_req = 1'b0;
    wait_ack(0, 0);
  endtask

  task automatic exit_txn(input int s, output bit err);
    step();
    exit_slot = 3'(s);
    exit_req  = 1'b1;
    wait_ack(1, 1);
    err = exit_err;
    step();
    exit_req = 1'b0;
    wait_ack(1, 0);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    bit ok;
    bit err;
    int slot;
    int exp_seq [8] = '{4, 5, 6, 7, 3, 2, 1, 0};
    reset     = 1'b1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = '0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_free", int'(free_count), 8);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_acks", int'({entry_ack, exit_ack}), 0);

    // First tie after reset: exit served first.
    step();
    exit_slot = 3'd3;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    wait_ack(1, 1);
    chk("tie1_exit_err", int'(exit_err), 1);
    chk("tie1_entry_wait", int'(entry_ack), 0);
    step();
    exit_req = 1'b0;
    wait_ack(0, 1);
    chk("tie1_entry_ok", int'(entry_ok), 1);
    chk("tie1_entry_slot", int'(entry_slot), 4);
    step();
    entry_req = 1'b0;
    wait_ack(0, 0);
    chk("tie1_occ", int'(occupancy), 8'h10);

    // Releasing a free slot reports an error.
    exit_txn(2, err);
    chk("free_exit_err", int'(err), 1);
    chk("free_exit_occ", int'(occupancy), 8'h10);

    // Exit served last, so entry wins this tie.
    step();
    exit_slot = 3'd4;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    wait_ack(0, 1);
    chk("tie2_entry_slot", int'(entry_slot), 5);
    chk("tie2_exit_wait", int'(exit_ack), 0);
    step();
    entry_req = 1'b0;
    wait_ack(1, 1);
    chk("tie2_exit_err", int'(exit_err), 0);
    step();
    exit_req = 1'b0;
    wait_ack(1, 0);
    chk("tie2_occ", int'(occupancy), 8'h20);
    exit_txn(5, err);
    chk("clear_occ", int'(occupancy), 0);

    // Fill the lot in allocation order.
    for (int i = 0; i < 8; i++) begin
      entry_txn(ok, slot);
      chk("fill_ok", int'(ok), 1);
      chk("fill_slot", slot, exp_seq[i]);
    end
    chk("fill_occ", int'(occupancy), 8'hFF);
    chk("fill_free", int'(free_count), 0);
    chk("fill_full", int'(full), 1);
    chk("model_full", int'(m_occ), 8'hFF);
    entry_txn(ok, slot);
    chk("ninth_ok", int'(ok), 0);
    chk("ninth_occ", int'(occupancy), 8'hFF);

    exit_txn(6, err);
    chk("exit6_err", int'(err), 0);
    chk("exit6_occ", int'(occupancy), 8'hBF);
    chk("exit6_free", int'(free_count), 1);
    entry_txn(ok, slot);
    chk("regrant_slot", slot, 6);
    chk("regrant_full", int'(full), 1);

    // Asynchronous reset while holding an entry grant.
    do_reset();
    entry_txn(ok, slot);
    step();
    entry_req = 1'b1;
    wait_ack(0, 1);
    chk("hold_occ", int'(occupancy), 8'h30);
    #1;
    reset = 1'b1;
    #1;
    chk("async_occ", int'(occupancy), 0);
    chk("async_ack", int'(entry_ack), 0);
    chk("async_free", int'(free_count), 8);
    step();
    step();
    reset = 1'b0;
    wait_ack(0, 1);
    chk("rearb_slot", int'(entry_slot), 4);
    step();
    entry_req = 1'b0;
    wait_ack(0, 0);
    chk("rearb_occ", int'(occupancy), 8'h10);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
